// File: rtl/mole_round_controller_if.sv
// Board-side bundle for the whack-a-mole round controller.
// The master drives tick/start/switches; the slave (controller) drives the display and status.
interface mole_round_controller_if;
  logic        tick;
  logic        start;
  logic [15:0] sw;
  logic [15:0] led;
  logic [5:0]  score;
  logic [1:0]  lives;
  logic        game_over;
  logic        win;

  modport master (
    output tick, start, sw,
    input  led, score, lives, game_over, win
  );

  modport slave (
    input  tick, start, sw,
    output led, score, lives, game_over, win
  );
endinterface

// File: rtl/mole_round_controller.sv
// Whack-a-mole round sequencer: LFSR mole pick, tick-timed window, hit/miss judging,
// score/lives tracking and a mole window that shrinks as the score climbs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start, display dark
// S_SPAWN  | one clk: pick mole index, load window timer
// S_ACTIVE | mole lit, judging switch edges and timeout
// S_HIT    | one clk: bump score, maybe speed up, end game on max score
// S_MISS   | one clk: drop a life, end game on last life
// S_GAP    | dark gap between moles, switch edges ignored
// S_DONE   | game over, all LEDs lit on a win, waiting for start
module mole_round_controller #(
  parameter logic [5:0] MAX_SCORE     = 6'd60,
  parameter logic [1:0] LIVES         = 2'd3,
  parameter logic [9:0] WIN_INIT      = 10'd800,
  parameter logic [9:0] WIN_MIN       = 10'd200,
  parameter logic [9:0] WIN_STEP      = 10'd50,
  parameter logic [7:0] SPEEDUP_EVERY = 8'd5,
  parameter logic [9:0] GAP_TICKS     = 10'd150
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mole_round_controller_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_ACTIVE,
    S_HIT,
    S_MISS,
    S_GAP,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_sw_s1;
  logic [15:0] r_sw_s2;
  logic [15:0] r_sw_q;
  logic [15:0] r_lfsr;

  logic [3:0]  r_idx;
  logic [3:0]  r_prev_idx;
  logic [5:0]  r_score;
  logic [1:0]  r_lives;
  logic [9:0]  r_window;
  logic [7:0]  r_hits_since;
  logic [9:0]  r_timer;
  logic [9:0]  r_gap;
  logic        r_win;
  logic [15:0] r_led;
  logic        r_game_over;

  logic [3:0]  w_idx_nxt;
  logic [3:0]  w_prev_idx_nxt;
  logic [5:0]  w_score_nxt;
  logic [1:0]  w_lives_nxt;
  logic [9:0]  w_window_nxt;
  logic [7:0]  w_hits_since_nxt;
  logic [9:0]  w_timer_nxt;
  logic [9:0]  w_gap_nxt;
  logic        w_win_nxt;
  logic [15:0] w_led_nxt;
  logic        w_game_over_nxt;

  logic [15:0] w_edge;
  logic        w_tgt_edge;
  logic        w_any_edge;
  logic        w_lfsr_fb;
  logic [3:0]  w_lfsr_idx;
  logic [3:0]  w_cand;
  logic [5:0]  w_score_inc;
  logic [7:0]  w_hits_inc;
  logic [9:0]  w_window_dec;

  // Two-flop synchroniser plus a delayed copy; any toggle gives a one-clk edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_sw_q  <= '0;
      r_lfsr  <= 16'hACE1;
    end else begin
      r_sw_s1 <= bus.sw;
      r_sw_s2 <= r_sw_s1;
      r_sw_q  <= r_sw_s2;
      r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_idx = r_lfsr[3:0];
  assign w_cand     = (w_lfsr_idx == r_prev_idx) ? (w_lfsr_idx + 4'd1) : w_lfsr_idx;

  assign w_edge     = r_sw_s2 ^ r_sw_q;
  assign w_tgt_edge = w_edge[r_idx];
  assign w_any_edge = |w_edge;

  assign w_score_inc  = (r_score >= MAX_SCORE) ? MAX_SCORE : (r_score + 6'd1);
  assign w_hits_inc   = r_hits_since + 8'd1;
  // Clamp to the floor before subtracting so the window can never wrap.
  assign w_window_dec = (r_window >= (WIN_MIN + WIN_STEP)) ? (r_window - WIN_STEP) : WIN_MIN;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_prev_idx   <= '0;
      r_score      <= '0;
      r_lives      <= '0;
      r_window     <= WIN_INIT;
      r_hits_since <= '0;
      r_timer      <= '0;
      r_gap        <= '0;
      r_win        <= 1'b0;
      r_led        <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_prev_idx   <= w_prev_idx_nxt;
      r_score      <= w_score_nxt;
      r_lives      <= w_lives_nxt;
      r_window     <= w_window_nxt;
      r_hits_since <= w_hits_since_nxt;
      r_timer      <= w_timer_nxt;
      r_gap        <= w_gap_nxt;
      r_win        <= w_win_nxt;
      r_led        <= w_led_nxt;
      r_game_over  <= w_game_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_prev_idx_nxt   = r_prev_idx;
    w_score_nxt      = r_score;
    w_lives_nxt      = r_lives;
    w_window_nxt     = r_window;
    w_hits_since_nxt = r_hits_since;
    w_timer_nxt      = r_timer;
    w_gap_nxt        = r_gap;
    w_win_nxt        = r_win;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt      = S_SPAWN;
          w_score_nxt      = '0;
          w_lives_nxt      = LIVES;
          w_window_nxt     = WIN_INIT;
          w_hits_since_nxt = '0;
          w_win_nxt        = 1'b0;
        end
      end
      S_SPAWN: begin
        w_idx_nxt      = w_cand;
        w_prev_idx_nxt = w_cand;
        w_timer_nxt    = r_window;
        w_state_nxt    = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.tick && (r_timer != 10'd0)) begin
          w_timer_nxt = r_timer - 10'd1;
        end
        // Target edge beats stray edges, which beat the timeout.
        if (w_tgt_edge) begin
          w_state_nxt = S_HIT;
        end else if (w_any_edge) begin
          w_state_nxt = S_MISS;
        end else if (bus.tick && (r_timer == 10'd1)) begin
          w_state_nxt = S_MISS;
        end
      end
      S_HIT: begin
        w_score_nxt = w_score_inc;
        if (w_score_inc == MAX_SCORE) begin
          w_state_nxt = S_DONE;
          w_win_nxt   = 1'b1;
        end else begin
          if (w_hits_inc >= SPEEDUP_EVERY) begin
            w_hits_since_nxt = '0;
            w_window_nxt     = w_window_dec;
          end else begin
            w_hits_since_nxt = w_hits_inc;
          end
          w_gap_nxt   = GAP_TICKS;
          w_state_nxt = S_GAP;
        end
      end
      S_MISS: begin
        w_lives_nxt = (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;
        if (r_lives <= 2'd1) begin
          w_state_nxt = S_DONE;
          w_win_nxt   = 1'b0;
        end else begin
          w_gap_nxt   = GAP_TICKS;
          w_state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (bus.tick) begin
          if (r_gap <= 10'd1) begin
            w_gap_nxt   = '0;
            w_state_nxt = S_SPAWN;
          end else begin
            w_gap_nxt = r_gap - 10'd1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    w_led_nxt       = '0;
    w_game_over_nxt = 1'b0;
    case (w_state_nxt)
      S_ACTIVE: begin
        w_led_nxt = 16'd1 << w_idx_nxt;
      end
      S_DONE: begin
        w_game_over_nxt = 1'b1;
        w_led_nxt       = w_win_nxt ? 16'hFFFF : 16'h0000;
      end
      default: begin
        w_led_nxt = '0;
      end
    endcase
  end

  assign bus.led       = r_led;
  assign bus.score     = r_score;
  assign bus.lives     = r_lives;
  assign bus.game_over = r_game_over;
  assign bus.win       = r_win;

endmodule
